// File: rtl/sem_pkg.sv
// Shared types and defaults for the signal controller and its pedestrian-request front end.
package sem_pkg;

  localparam int unsigned PED_DIV_DEFAULT           = 50000;
  localparam int unsigned PED_DEB_SAMPLES_DEFAULT   = 4;
  localparam int unsigned PED_LOCKOUT_TICKS_DEFAULT = 1000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    LOCK = 2'b10
  } ped_state_t;

  // Lamp colour encoding as seen by the light controller.
  typedef enum logic [1:0] {
    LIGHT_OFF    = 2'b00,
    LIGHT_RED    = 2'b01,
    LIGHT_AMBER  = 2'b10,
    LIGHT_GREEN  = 2'b11
  } light_t;

endpackage

// File: rtl/ped_debounce.sv
// Push-button synchroniser, sample-tick prescaler and counting debouncer.
module ped_debounce
  import sem_pkg::*;
#(
  parameter int unsigned DIV         = PED_DIV_DEFAULT,
  parameter int unsigned DEB_SAMPLES = PED_DEB_SAMPLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic db_level,
  output logic tick_c
);

  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned STAB_W = $clog2(DEB_SAMPLES + 1);

  logic              r_s1;
  logic              r_s2;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic              r_db_level;
  logic              w_tick;

  assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Level flips only after DEB_SAMPLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stab_cnt <= '0;
      r_db_level <= 1'b0;
    end else if (w_tick) begin
      if (r_s2 == r_db_level) begin
        r_stab_cnt <= '0;
      end else if (r_stab_cnt == STAB_W'(DEB_SAMPLES - 1)) begin
        r_db_level <= r_s2;
        r_stab_cnt <= '0;
      end else begin
        r_stab_cnt <= r_stab_cnt + STAB_W'(1);
      end
    end
  end

  assign db_level = r_db_level;
  assign tick_c   = w_tick;

endmodule

// File: rtl/ped_request.sv
// Pedestrian-request conditioner: debounced rising edge latches one request held until served.
// Optional post-service lockout compiled in with PED_REQ_LOCKOUT_EN.
module ped_request
  import sem_pkg::*;
#(
  parameter int unsigned DIV           = PED_DIV_DEFAULT,
  parameter int unsigned DEB_SAMPLES   = PED_DEB_SAMPLES_DEFAULT,
  parameter int unsigned LOCKOUT_TICKS = PED_LOCKOUT_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic served,
  output logic bt,
  output logic press,
  output logic lockout
);

  logic       w_db_level;
  logic       w_tick;
  logic       w_db_rise;
  logic       r_db_level_q;
  ped_state_t r_state;
  ped_state_t w_state_next;
  logic       w_press_next;
  logic       r_bt;
  logic       r_press;

  ped_debounce #(
    .DIV         (DIV),
    .DEB_SAMPLES (DEB_SAMPLES)
  ) u_deb (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_raw  (btn_raw),
    .db_level (w_db_level),
    .tick_c   (w_tick)
  );

  assign w_db_rise = w_db_level & ~r_db_level_q;

`ifdef PED_REQ_LOCKOUT_EN
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_TICKS + 1);

  logic [LOCK_W-1:0] r_lock_cnt;
  logic              w_lock_done;
  logic              r_lockout;

  // Counts sample ticks spent in LOCK; cleared whenever we are elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
    end else if (r_state != LOCK) begin
      r_lock_cnt <= '0;
    end else if (w_tick) begin
      r_lock_cnt <= r_lock_cnt + LOCK_W'(1);
    end
  end

  assign w_lock_done = w_tick && (r_lock_cnt == LOCK_W'(LOCKOUT_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lockout <= 1'b0;
    end else begin
      r_lockout <= (w_state_next == LOCK);
    end
  end

  assign lockout = r_lockout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{w_tick, 32'(LOCKOUT_TICKS)};
  assign lockout      = 1'b0;
`endif

  // Next state; served in REQ takes priority over a coincident edge.
  always_comb begin
    w_state_next = r_state;
    w_press_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_db_rise) begin
          w_state_next = REQ;
          w_press_next = 1'b1;
        end
      end
      REQ: begin
        if (served) begin
`ifdef PED_REQ_LOCKOUT_EN
          w_state_next = LOCK;
`else
          w_state_next = IDLE;
`endif
        end
      end
`ifdef PED_REQ_LOCKOUT_EN
      LOCK: begin
        if (w_lock_done) begin
          w_state_next = IDLE;
        end
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_db_level_q <= 1'b0;
      r_bt         <= 1'b0;
      r_press      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_db_level_q <= w_db_level;
      r_bt         <= (w_state_next == REQ);
      r_press      <= w_press_next;
    end
  end

  assign bt    = r_bt;
  assign press = r_press;

endmodule

// File: tb/tb_ped_request.sv
// Directed bench for ped_request with DIV=4, DEB_SAMPLES=3, LOCKOUT_TICKS=5.
module tb_ped_request;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DEB   = 3;
  localparam int unsigned LOCKT = 5;

`ifdef PED_REQ_LOCKOUT_EN
  localparam int LOCK_EN = 1;
`else
  localparam int LOCK_EN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic served;
  logic bt;
  logic press;
  logic lockout;

  int n_checks = 0;
  int n_fail   = 0;
  int press_cnt = 0;
  int press_run = 0;
  int press_run_max = 0;

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_bt;
  } vec_t;

  vec_t vecs[7];

  ped_request #(
    .DIV           (DIV),
    .DEB_SAMPLES   (DEB),
    .LOCKOUT_TICKS (LOCKT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .served  (served),
    .bt      (bt),
    .press   (press),
    .lockout (lockout)
  );

  always #5 clk = ~clk;

  // Count press pulses and track the longest run of consecutive high samples.
  always @(negedge clk) begin
    if (press) begin
      press_cnt <= press_cnt + 1;
      press_run <= press_run + 1;
      if (press_run + 1 > press_run_max) press_run_max <= press_run + 1;
    end else begin
      press_run <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    served  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic serve();
    served = 1'b1;
    step(1);
    served = 1'b0;
  endtask

  // Button rises after edge 10 (edges counted from reset release), held 40 cycles.
  task automatic clean_press(input string tag);
    int rise_at;
    int press_at;
    int p0;
    rise_at  = 0;
    press_at = 0;
    do_reset();
    p0 = press_cnt;
    step(10);
    btn_raw = 1'b1;
    for (int k = 11; k <= 50; k++) begin
      step(1);
      if (bt && rise_at == 0) rise_at = k;
      if (press && press_at == 0) press_at = k;
    end
    btn_raw = 1'b0;
    check_rng({tag, "_bt_rise_cycle"}, rise_at, 24, 30);
    check({tag, "_press_same_cycle"}, press_at, rise_at);
    step(30);
    check({tag, "_bt_held_after_release"}, int'(bt), 1);
    check({tag, "_press_count"}, press_cnt - p0, 1);
  endtask

  initial begin
    int p0;
    int lk;
    int found;
    int bt_seen;

    vecs[0] = '{hi: 1,  lo: 20, reps: 1, exp_bt: 0};
    vecs[1] = '{hi: 4,  lo: 20, reps: 1, exp_bt: 0};
    vecs[2] = '{hi: 8,  lo: 20, reps: 1, exp_bt: 0};
    vecs[3] = '{hi: 3,  lo: 3,  reps: 7, exp_bt: 0};
    vecs[4] = '{hi: 1,  lo: 5,  reps: 6, exp_bt: 0};
    vecs[5] = '{hi: 14, lo: 30, reps: 1, exp_bt: 1};
    vecs[6] = '{hi: 20, lo: 30, reps: 1, exp_bt: 1};

    rst_n   = 1'b0;
    btn_raw = 1'b0;
    served  = 1'b0;
    #12;
    check("reset_bt", int'(bt), 0);
    check("reset_press", int'(press), 0);
    check("reset_lockout", int'(lockout), 0);

    clean_press("clean");

    // Service and lockout window.
    serve();
    check("served_bt_low", int'(bt), 0);
    check("served_lockout", int'(lockout), LOCK_EN);
    lk = 0;
    for (int k = 0; k < 40; k++) begin
      if (lockout) lk++;
      step(1);
    end
    check_rng("lockout_length", lk, LOCK_EN * 16, LOCK_EN * 24);
    check("lockout_released", int'(lockout), 0);

    // Held button through service.
    p0 = press_cnt;
    btn_raw = 1'b1;
    step(30);
    check("held_press_bt", int'(bt), 1);
    check("held_press_count", press_cnt - p0, 1);
    p0 = press_cnt;
    serve();
    step(30);
    check("held_after_serve_bt", int'(bt), 0);
    check("held_after_serve_press", press_cnt - p0, 0);

    // Release and press inside the lockout window.
    btn_raw = 1'b0;
    step(30);
    btn_raw = 1'b1;
    step(30);
    check("rearm_bt", int'(bt), 1);
    btn_raw = 1'b0;
    step(30);
    check("release_in_req_bt", int'(bt), 1);
    p0 = press_cnt;
    serve();
    btn_raw = 1'b1;
    step(16);
    check("press_in_lock_lockout", int'(lockout), LOCK_EN);
    step(30);
    check("press_in_lock_bt", int'(bt), 1 - LOCK_EN);
    check("press_in_lock_count", press_cnt - p0, 1 - LOCK_EN);
`ifndef PED_REQ_LOCKOUT_EN
    serve();
    step(5);
`endif
    btn_raw = 1'b0;
    step(30);
    p0 = press_cnt;
    btn_raw = 1'b1;
    step(30);
    check("after_lock_bt", int'(bt), 1);
    check("after_lock_press", press_cnt - p0, 1);

    // Collision: served lands in the same cycle as a fresh debounced edge.
    btn_raw = 1'b0;
    step(30);
    p0 = press_cnt;
    btn_raw = 1'b1;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      if (dut.w_db_rise) begin
        found = 1;
        break;
      end
    end
    check("collision_edge_seen", found, 1);
    serve();
    check("collision_bt", int'(bt), 0);
    check("collision_lockout", int'(lockout), LOCK_EN);
    step(30);
    check("collision_bt_later", int'(bt), 0);
    check("collision_press", press_cnt - p0, 0);

    // Asynchronous reset while a request is latched and a debounce count is running.
    btn_raw = 1'b0;
    step(30);
    btn_raw = 1'b1;
    step(30);
    check("pre_reset_bt", int'(bt), 1);
    btn_raw = 1'b0;
    step(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_bt", int'(bt), 0);
    check("async_reset_press", int'(press), 0);
    check("async_reset_lockout", int'(lockout), 0);
    clean_press("post_reset");

    serve();
    step(30);

    // Glitch and bounce table.
    for (int v = 0; v < 7; v++) begin
      p0 = press_cnt;
      bt_seen = 0;
      for (int r = 0; r < vecs[v].reps; r++) begin
        btn_raw = 1'b1;
        for (int c = 0; c < vecs[v].hi; c++) begin
          step(1);
          if (bt) bt_seen = 1;
        end
        btn_raw = 1'b0;
        for (int c = 0; c < vecs[v].lo; c++) begin
          step(1);
          if (bt) bt_seen = 1;
        end
      end
      for (int c = 0; c < 24; c++) begin
        step(1);
        if (bt) bt_seen = 1;
      end
      check($sformatf("vec%0d_bt", v), bt_seen, vecs[v].exp_bt);
      check($sformatf("vec%0d_press", v), press_cnt - p0, vecs[v].exp_bt);
      if (bt) begin
        serve();
        step(30);
      end
    end

    check("press_pulse_width", press_run_max, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
